adc_moving_avg: RTL and testbench
=================================

// Module: adc_moving_avg
// PURPOSE
//  Two-channel running (boxcar) average between the ADC capture stage and the
//  fuzzy controller. Each ADC conversion strobe pushes one 8-bit sample per
//  channel into a circular buffer of depth 2^LOG2N. Running sums are updated
//  incrementally; the averaged T (ch0) and L (ch1) values feed the fuzzy
//  controller and the BCD/LCD path, de-noising the light/temperature readings.
// PARAMETERS
//  WIDTH  8  sample and output width per channel
//  LOG2N  3  log2 of window depth N (N = 8 samples)
// PORTS
//  clk           in   1      system clock; all logic on rising edge
//  reset         in   1      asynchronous, active-high reset
//  clear         in   1      synchronous window flush, priority over sample_valid
//  sample_valid  in   1      one-cycle strobe: adc0_in/adc1_in hold a new sample
//  adc0_in       in   WIDTH  channel 0 sample (ADC0)
//  adc1_in       in   WIDTH  channel 1 sample (ADC1)
//  T             out  WIDTH  channel 0 output (raw while unprimed, else average)
//  L             out  WIDTH  channel 1 output (raw while unprimed, else average)
//  avg_valid     out  1      one-cycle pulse: T/L just updated
//  primed        out  1      high once N samples have been taken since reset/clear
// BEHAVIOUR
//  - reset: T=L=0, avg_valid=0, primed=0, sums=0, wr_ptr=0, fill count=0.
//    Buffer RAM is not reset; its contents are masked until primed.
//  - Per channel: buf[N] x WIDTH, sum (WIDTH+LOG2N bits), shared wr_ptr
//    (LOG2N bits, wraps N-1 -> 0), fill count saturating at N.
//  - Edge k with sample_valid=1, clear=0:
//      oldest = primed ? buf[wr_ptr] : 0;  sum <= sum + new - oldest;
//      buf[wr_ptr] <= new; wr_ptr <= wr_ptr+1; fill++ (sat at N);
//      primed <= 1 when fill reaches N (on the N-th sample).
//  - Edge k+1: T/L <= primed ? sum>>LOG2N (truncate) : sample captured at k;
//    avg_valid=1 for exactly that cycle. Fixed latency 2 edges strobe->output.
//    The N-th sample's output is already the full average.
//  - Sum cannot overflow: N*(2^WIDTH-1) < 2^(WIDTH+LOG2N). No saturation logic.
//  - Back-to-back sample_valid on consecutive cycles: every strobe is accepted
//    and produces its own avg_valid pulse (pipelined, no stall, no drop).
//  - clear=1: sums, wr_ptr, fill, primed <= 0; T/L hold last value; avg_valid
//    pulse pending from the previous edge still fires; a sample_valid in the
//    same cycle as clear is discarded and generates no avg_valid.
//  - reset asserted mid-operation: all state returns to reset values at once;
//    pending avg_valid is cancelled.
//  - T/L change only on an avg_valid edge; otherwise hold (stable for LCD/BCD).
// TESTING
//  1 Assert reset mid-stream -> T=L=0, avg_valid=0, primed=0 immediately.
//  2 8 strobes of adc0=0x80, adc1=0x40 -> T/L pass raw values on strobes 1-7,
//    primed rises with strobe 8, then T=0x80, L=0x40.
//  3 Primed at 0x00, then 8 strobes of 0xFF on ch0 -> T sequence 0x1F,0x3F,
//    0x5F,0x7F,0x9F,0xBF,0xDF,0xFF; all values exact (no drift after wrap).
//  4 sample_valid held high 16 consecutive cycles with ramp 0..15 -> 16
//    avg_valid pulses, each 2 edges after its strobe; final T=(8+..+15)>>3=0x0B.
//  5 clear after 5 strobes (with simultaneous strobe) -> primed=0, no
//    avg_valid for that strobe, T holds; next 7 strobes raw, 8th gives average.
//  6 Randomised 1000 strobes vs reference model (mod-N window, truncate) ->
//    T/L/avg_valid/primed match every cycle.

Source files
------------

// File: rtl/adc_moving_avg.sv
// Two-channel boxcar average over the last 2^LOG2N ADC samples.
// Each strobe updates a running sum incrementally from a circular buffer.
// T/L show the raw sample until the window has filled, then the window mean.
// Both outputs are registered and change one edge after the sample is absorbed.
module adc_moving_avg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LOG2N = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] adc0_in,
   input  logic [WIDTH-1:0] adc1_in,
   output logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] L,
   output logic             avg_valid,
   output logic             primed
);

   localparam int unsigned N  = 1 << LOG2N;
   localparam int unsigned SW = WIDTH + LOG2N;
   localparam int unsigned FW = LOG2N + 1;

   logic [WIDTH-1:0] ram0 [N];
   logic [WIDTH-1:0] ram1 [N];

   logic [SW-1:0]    sum0, sum1;
   logic [SW-1:0]    sum0_nxt_c, sum1_nxt_c;
   logic [WIDTH-1:0] oldest0_c, oldest1_c;
   logic [LOG2N-1:0] wr_ptr;
   logic [FW-1:0]    fill;
   logic             pend;
   logic [WIDTH-1:0] cap0, cap1;
   logic             take_c;

   // Evicted sample is only meaningful once the window is full.
   always_comb begin
      take_c     = sample_valid & ~clear;
      oldest0_c  = '0;
      oldest1_c  = '0;
      if (primed) begin
         oldest0_c = ram0[wr_ptr];
         oldest1_c = ram1[wr_ptr];
      end
      sum0_nxt_c = sum0 + SW'(adc0_in) - SW'(oldest0_c);
      sum1_nxt_c = sum1 + SW'(adc1_in) - SW'(oldest1_c);
   end

   // Sample buffer: not reset, masked by primed until fully written.
   always_ff @(posedge clk) begin
      if (take_c) begin
         ram0[wr_ptr] <= adc0_in;
         ram1[wr_ptr] <= adc1_in;
      end
   end

   // Window bookkeeping, capture of the raw sample, and output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum0      <= '0;
         sum1      <= '0;
         wr_ptr    <= '0;
         fill      <= '0;
         primed    <= 1'b0;
         pend      <= 1'b0;
         cap0      <= '0;
         cap1      <= '0;
         T         <= '0;
         L         <= '0;
         avg_valid <= 1'b0;
      end else begin
         // Output stage consumes the strobe absorbed on the previous edge.
         avg_valid <= pend;
         if (pend) begin
            if (primed) begin
               T <= WIDTH'(sum0 >> LOG2N);
               L <= WIDTH'(sum1 >> LOG2N);
            end else begin
               T <= cap0;
               L <= cap1;
            end
         end

         // Window update; clear wins and discards a coincident strobe.
         if (clear) begin
            sum0   <= '0;
            sum1   <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            primed <= 1'b0;
            pend   <= 1'b0;
         end else if (sample_valid) begin
            sum0   <= sum0_nxt_c;
            sum1   <= sum1_nxt_c;
            wr_ptr <= wr_ptr + LOG2N'(1);
            cap0   <= adc0_in;
            cap1   <= adc1_in;
            pend   <= 1'b1;
            if (fill != FW'(N)) begin
               fill <= fill + FW'(1);
            end
            if (fill == FW'(N - 1)) begin
               primed <= 1'b1;
            end
         end else begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg with a window model checked after every edge.
module tb_adc_moving_avg;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] adc0_in = '0;
   logic [7:0] adc1_in = '0;
   logic [7:0] T, L;
   logic       avg_valid, primed;

   int total = 0;
   int bad   = 0;

   // Window model: queues of the most recent samples, emptied by clear/reset.
   logic [7:0] w0 [$];
   logic [7:0] w1 [$];
   logic       m_pend = 1'b0;
   logic [7:0] m_pt = '0, m_pl = '0;
   logic [7:0] m_T = '0, m_L = '0;
   logic       m_av = 1'b0;

   logic [7:0] t3 [8] = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};

   adc_moving_avg #(.WIDTH(8), .LOG2N(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .sample_valid (sample_valid),
      .adc0_in      (adc0_in),
      .adc1_in      (adc1_in),
      .T            (T),
      .L            (L),
      .avg_valid    (avg_valid),
      .primed       (primed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".T"}, T, m_T);
      chk({tag, ".L"}, L, m_L);
      chk({tag, ".avg_valid"}, {7'b0, avg_valid}, {7'b0, m_av});
      chk({tag, ".primed"}, {7'b0, primed}, {7'b0, (w0.size() == 8)});
   endtask

   task automatic model_reset();
      w0.delete();
      w1.delete();
      m_pend = 1'b0;
      m_T    = '0;
      m_L    = '0;
      m_av   = 1'b0;
   endtask

   // One clock edge: drive inputs, advance the model, compare 1 ns after the edge.
   task automatic step(input logic sv, input logic clr, input logic [7:0] a, input logic [7:0] b,
                       input string tag);
      int s0, s1;
      logic np;
      sample_valid = sv;
      clear        = clr;
      adc0_in      = a;
      adc1_in      = b;
      @(posedge clk);
      m_av = m_pend;
      if (m_pend) begin
         m_T = m_pt;
         m_L = m_pl;
      end
      np = 1'b0;
      if (clr) begin
         w0.delete();
         w1.delete();
      end else if (sv) begin
         w0.push_back(a);
         w1.push_back(b);
         if (w0.size() > 8) begin
            void'(w0.pop_front());
            void'(w1.pop_front());
         end
         if (w0.size() == 8) begin
            s0 = 0;
            s1 = 0;
            foreach (w0[i]) s0 += int'(w0[i]);
            foreach (w1[i]) s1 += int'(w1[i]);
            m_pt = 8'(s0 / 8);
            m_pl = 8'(s1 / 8);
         end else begin
            m_pt = a;
            m_pl = b;
         end
         np = 1'b1;
      end
      m_pend = np;
      #1;
      sample_valid = 1'b0;
      clear        = 1'b0;
      chk_model(tag);
   endtask

   initial begin
      int pulses;
      logic [7:0] r0, r1;

      // Reset state
      #12;
      chk("rst.T", T, 8'h00);
      chk("rst.L", L, 8'h00);
      chk("rst.avg_valid", {7'b0, avg_valid}, 8'h00);
      chk("rst.primed", {7'b0, primed}, 8'h00);
      reset = 1'b0;

      // Constant fill: raw pass-through, primed with the 8th strobe
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'h80, 8'h40, "fill");
         if (i > 0) begin
            chk("fill.T", T, 8'h80);
            chk("fill.L", L, 8'h40);
         end
         chk("fill.primed", {7'b0, primed}, (i == 7) ? 8'h01 : 8'h00);
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, "fill_out");
      chk("fill_out.T", T, 8'h80);
      chk("fill_out.L", L, 8'h40);
      chk("fill_out.avg_valid", {7'b0, avg_valid}, 8'h01);

      // Prime at zero, then ramp ch0 to full scale
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00, "zero");
      step(1'b0, 1'b0, 8'h00, 8'h00, "zero_out");
      chk("zero.T", T, 8'h00);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'hFF, 8'h00, "ff");
         if (i > 0) chk("ff.T", T, t3[i-1]);
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, "ff_out");
      chk("ff_out.T", T, t3[7]);
      chk("ff_out.L", L, 8'h00);

      // Back-to-back ramp after a flush
      step(1'b0, 1'b1, 8'h00, 8'h00, "clr4");
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'(i), 8'(15 - i), "ramp");
         if (avg_valid) pulses++;
         if (i > 0) chk("ramp.avg_valid", {7'b0, avg_valid}, 8'h01);
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, "ramp_out");
      if (avg_valid) pulses++;
      chk("ramp.pulses", 8'(pulses), 8'd16);
      chk("ramp.T", T, 8'h0B);
      chk("ramp.L", L, 8'h03);
      step(1'b0, 1'b0, 8'h00, 8'h00, "ramp_idle");
      chk("ramp_idle.avg_valid", {7'b0, avg_valid}, 8'h00);

      // Clear with a coincident strobe after five samples
      step(1'b0, 1'b1, 8'h00, 8'h00, "clr5a");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10, 8'h20, "pre");
      step(1'b1, 1'b1, 8'h99, 8'h99, "clr5");
      chk("clr5.avg_valid", {7'b0, avg_valid}, 8'h01);
      chk("clr5.primed", {7'b0, primed}, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00, "clr5_after");
      chk("clr5_after.avg_valid", {7'b0, avg_valid}, 8'h00);
      chk("clr5_after.T", T, 8'h10);
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 8'(i * 8), 8'h20, "refill");
         step(1'b0, 1'b0, 8'h00, 8'h00, "refill_out");
         if (i == 7) chk("refill7.T", T, 8'h38);
         if (i == 7) chk("refill7.primed", {7'b0, primed}, 8'h00);
      end
      chk("refill8.T", T, 8'h24);
      chk("refill8.L", L, 8'h20);
      chk("refill8.primed", {7'b0, primed}, 8'h01);

      // Asynchronous reset with a strobe in flight
      step(1'b1, 1'b0, 8'h55, 8'hAA, "inflight");
      reset = 1'b1;
      #1;
      chk("mid_rst.T", T, 8'h00);
      chk("mid_rst.L", L, 8'h00);
      chk("mid_rst.avg_valid", {7'b0, avg_valid}, 8'h00);
      chk("mid_rst.primed", {7'b0, primed}, 8'h00);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b0, 8'h00, 8'h00, "post_rst");
      chk("post_rst.avg_valid", {7'b0, avg_valid}, 8'h00);

      // Random strobes, gaps and occasional clears against the window model
      for (int i = 0; i < 1000; i++) begin
         r0 = 8'($urandom_range(0, 255));
         r1 = 8'($urandom_range(0, 255));
         step(($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0), r0, r1, "rand");
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, "drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
